lcd_bus_reader: RTL and testbench

//  Read side of the HD44780 8-bit parallel LCD interface (RW=1 transactions).
//  On request, reads the busy-flag/address-counter register (RS=0) or one DDRAM/CGRAM data byte (RS=1).

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_bus_reader_if.sv | 29 ++
 rtl/lcd_e_timer.sv | 30 +++
 rtl/lcd_bus_reader.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 read path: FSM encoding, default
// timing constants, pin level names and small constant helper functions.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_E_LOW  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Defaults sized for a 50 MHz system clock
    localparam int T_AS_CYC_DEF  = 3;
    localparam int T_PW_CYC_DEF  = 25;
    localparam int T_LOW_CYC_DEF = 25;
    localparam int POLL_MAX_DEF  = 4096;

    localparam logic RS_CMD   = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int BF_BIT = 7;

    // A zero-length interval makes no sense on the bus; treat it as one cycle
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Counter width able to hold v-1, never narrower than one bit
    function automatic int cnt_width(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return m;
    endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/result handshake plus LCD pin bundle of the read path.
// slave: the reader block. master: the client / pin side.
interface lcd_bus_reader_if;
    logic       req;
    logic       rs_sel;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       bf;
    logic [6:0] ac;
    logic       timeout;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       lcd_db_oe;
    logic [7:0] lcd_db_i;

    modport slave (
        input  req, rs_sel, lcd_db_i,
        output busy, done, rd_data, bf, ac, timeout,
        output lcd_rs, lcd_rw, lcd_e, lcd_db_oe
    );

    modport master (
        output req, rs_sel, lcd_db_i,
        input  busy, done, rd_data, bf, ac, timeout,
        input  lcd_rs, lcd_rw, lcd_e, lcd_db_oe
    );
endinterface

// File: rtl/lcd_e_timer.sv
// Loadable down-counter with zero flag; one instance times every phase of
// the read cycle (address setup, E high, E low).
module lcd_e_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit read path (RW=1): reads the BF/AC register (rs_sel=0) or a
// data byte (rs_sel=1). All pin and result outputs are registered so E
// cannot glitch. Optional build macro LCD_READ_POLL_EN: BF/AC reads repeat
// until BF clears or POLL_MAX reads have been made.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int T_AS_CYC  = T_AS_CYC_DEF,
    parameter int T_PW_CYC  = T_PW_CYC_DEF,
    parameter int T_LOW_CYC = T_LOW_CYC_DEF,
    parameter int POLL_MAX  = POLL_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_reader_if.slave   bus
);

    localparam int AS_EFF   = at_least_one(T_AS_CYC);
    localparam int PW_EFF   = at_least_one(T_PW_CYC);
    localparam int LOW_EFF  = at_least_one(T_LOW_CYC);
    localparam int POLL_EFF = at_least_one(POLL_MAX);
    localparam int TW       = cnt_width(max4(AS_EFF, PW_EFF, LOW_EFF, POLL_EFF));

    localparam logic [TW-1:0] AS_LOAD  = TW'(AS_EFF - 1);
    localparam logic [TW-1:0] PW_LOAD  = TW'(PW_EFF - 1);
    localparam logic [TW-1:0] LOW_LOAD = TW'(LOW_EFF - 1);

    state_e      state_q;
    logic        rs_sel_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  rd_data_q;
    logic        bf_q;
    logic [6:0]  ac_q;
    logic        lcd_rs_q;
    logic        lcd_rw_q;
    logic        lcd_e_q;
    logic        lcd_db_oe_q;

    logic          timer_load_d;
    logic [TW-1:0] timer_val_d;
    logic          timer_zero_s;
    logic          poll_again_s;

`ifdef LCD_READ_POLL_EN
    localparam int PCW = cnt_width(POLL_EFF);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_EFF - 1);

    logic [PCW-1:0] poll_cnt_q;
    logic           timeout_q;

    // Another BF/AC read is due while the LCD reports busy and reads remain
    always_comb begin
        poll_again_s = 1'b0;
        if ((rs_sel_q == RS_CMD) && rd_data_q[BF_BIT] && (poll_cnt_q != POLL_LAST)) begin
            poll_again_s = 1'b1;
        end else begin
            poll_again_s = 1'b0;
        end
    end
`else
    // Single-read build: never repeat a read
    always_comb begin
        poll_again_s = 1'b0;
    end
`endif

    // Timer reloads at each phase boundary of the read cycle
    always_comb begin
        timer_load_d = 1'b0;
        timer_val_d  = {TW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = AS_LOAD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (timer_zero_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = PW_LOAD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            ST_E_HIGH: begin
                if (timer_zero_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = LOW_LOAD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            ST_E_LOW: begin
                if (timer_zero_s && poll_again_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = AS_LOAD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            default: begin
                timer_load_d = 1'b0;
            end
        endcase
    end

    lcd_e_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load_d),
        .load_val_i (timer_val_d),
        .zero_o     (timer_zero_s)
    );

    // Read-cycle FSM with registered pin, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rs_sel_q    <= RS_CMD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            bf_q        <= 1'b0;
            ac_q        <= 7'h00;
            lcd_rs_q    <= RS_CMD;
            lcd_rw_q    <= RW_WRITE;
            lcd_e_q     <= 1'b0;
            lcd_db_oe_q <= 1'b0;
`ifdef LCD_READ_POLL_EN
            poll_cnt_q  <= {PCW{1'b0}};
            timeout_q   <= 1'b0;
`endif
        end else begin
            // The bus is only ever read here; the write path owns driving it
            lcd_db_oe_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        state_q  <= ST_SETUP;
                        rs_sel_q <= bus.rs_sel;
                        busy_q   <= 1'b1;
                        lcd_rs_q <= bus.rs_sel;
                        lcd_rw_q <= RW_READ;
`ifdef LCD_READ_POLL_EN
                        poll_cnt_q <= {PCW{1'b0}};
                        timeout_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (timer_zero_s) begin
                        state_q <= ST_E_HIGH;
                        lcd_e_q <= 1'b1;
                    end else begin
                        state_q <= ST_SETUP;
                    end
                end
                ST_E_HIGH: begin
                    if (timer_zero_s) begin
                        // Sample the pins on the same edge that E falls
                        state_q   <= ST_E_LOW;
                        lcd_e_q   <= 1'b0;
                        rd_data_q <= bus.lcd_db_i;
                        bf_q      <= (rs_sel_q == RS_CMD) ? bus.lcd_db_i[BF_BIT] : 1'b0;
                        ac_q      <= (rs_sel_q == RS_CMD) ? bus.lcd_db_i[6:0] : 7'h00;
                    end else begin
                        state_q <= ST_E_HIGH;
                    end
                end
                ST_E_LOW: begin
                    if (timer_zero_s && poll_again_s) begin
                        state_q <= ST_SETUP;
`ifdef LCD_READ_POLL_EN
                        poll_cnt_q <= poll_cnt_q + {{(PCW-1){1'b0}}, 1'b1};
`endif
                    end else if (timer_zero_s) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        lcd_rw_q <= RW_WRITE;
                        lcd_rs_q <= RS_CMD;
`ifdef LCD_READ_POLL_EN
                        // Still busy after the last allowed read means we gave up
                        timeout_q <= (rs_sel_q == RS_CMD) && rd_data_q[BF_BIT];
`endif
                    end else begin
                        state_q <= ST_E_LOW;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    lcd_e_q  <= 1'b0;
                    lcd_rw_q <= RW_WRITE;
                    lcd_rs_q <= RS_CMD;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.bf        = bf_q;
    assign bus.ac        = ac_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = lcd_rw_q;
    assign bus.lcd_e     = lcd_e_q;
    assign bus.lcd_db_oe = lcd_db_oe_q;
`ifdef LCD_READ_POLL_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader at default timing (3/25/25).
// Polling scenarios run only when LCD_READ_POLL_EN is defined (POLL_MAX=8).
module tb_lcd_bus_reader;

`ifdef LCD_READ_POLL_EN
    localparam int POLL_MAX_TB = 8;
`else
    localparam int POLL_MAX_TB = 4096;
`endif

    logic clk = 1'b0;
    logic rst_n;
    lcd_bus_reader_if bus();

    lcd_bus_reader #(
        .T_AS_CYC  (3),
        .T_PW_CYC  (25),
        .T_LOW_CYC (25),
        .POLL_MAX  (POLL_MAX_TB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LCD model state and per-transaction observations
    logic [7:0] db_val;
    int bf_reads;
    int n_cyc, pulses, high_total, pre_rise, rs_err, rw_err, busy_err;
    bit done_seen;
    bit oe_bad = 1'b0;

    // The reader must never drive the data bus
    always @(negedge clk) begin
        if (bus.lcd_db_oe !== 1'b0) oe_bad = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte the LCD model presents during read number k (1-based)
    function automatic logic [7:0] model_byte(input int k);
        return (k <= bf_reads) ? (db_val | 8'h80) : db_val;
    endfunction

    // Raise req before an edge in IDLE; return #1 after the accept edge
    task automatic issue(input logic rs, input bit hold);
        bus.lcd_db_i = model_byte(1);
        @(negedge clk);
        bus.rs_sel = rs;
        bus.req    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.req = 1'b0;
    endtask

    // Sample once per cycle until done, recording pin behaviour
    task automatic wait_done(input logic exp_rs, input int limit, input bit glitch);
        logic prev_e;
        prev_e = 1'b0;
        n_cyc = 0; pulses = 0; high_total = 0; pre_rise = 0;
        rs_err = 0; rw_err = 0; busy_err = 0; done_seen = 1'b0;
        while (!done_seen && n_cyc <= limit) begin
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                if (bus.lcd_e === 1'b1 && prev_e === 1'b0) begin
                    pulses++;
                    bus.lcd_db_i = model_byte(pulses);
                end
                if (bus.lcd_e === 1'b1) high_total++;
                if (pulses == 0 && bus.lcd_e === 1'b0 && bus.lcd_rw === 1'b1) pre_rise++;
                if (bus.lcd_rw !== 1'b1) rw_err++;
                if (bus.lcd_rs !== exp_rs) rs_err++;
                if (bus.busy !== 1'b1) busy_err++;
                prev_e = bus.lcd_e;
                if (glitch) bus.req = (n_cyc == 10 || n_cyc == 40);
                @(posedge clk);
                #1;
                n_cyc++;
            end
        end
        chk("done_seen", {31'd0, done_seen}, 32'd1);
    endtask

    // Common checks on the done cycle and the cycle after it
    task automatic post_done(input logic [7:0] exp_rd, input logic exp_bf, input logic [6:0] exp_ac);
        chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_rd});
        chk("bf", {31'd0, bus.bf}, {31'd0, exp_bf});
        chk("ac", {25'd0, bus.ac}, {25'd0, exp_ac});
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("rw_at_done", {31'd0, bus.lcd_rw}, 32'd0);
        chk("rs_at_done", {31'd0, bus.lcd_rs}, 32'd0);
        chk("rw_held", rw_err, 32'd0);
        chk("busy_held", busy_err, 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int dcount;
        logic [7:0] rd;
        rst_n = 1'b0;
        bus.req = 1'b0;
        bus.rs_sel = 1'b0;
        bus.lcd_db_i = 8'h00;
        db_val = 8'h00;
        bf_reads = 0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        chk("rst_bf", {31'd0, bus.bf}, 32'd0);
        chk("rst_ac", {25'd0, bus.ac}, 32'd0);
        chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
        chk("rst_lcd_rs", {31'd0, bus.lcd_rs}, 32'd0);
        chk("rst_lcd_rw", {31'd0, bus.lcd_rw}, 32'd0);
        chk("rst_lcd_e", {31'd0, bus.lcd_e}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // BF/AC read returning 8'h45. The accept cycle is cycle 1, so done in
        // cycle 55 is seen 53 edges after the accept edge (3+25+25 cycles).
        db_val = 8'h45; bf_reads = 0;
        issue(1'b0, 1'b0);
        wait_done(1'b0, 200, 1'b0);
        chk("ac_latency", n_cyc, 32'd53);
        chk("ac_pulses", pulses, 32'd1);
        chk("ac_e_width", high_total, 32'd25);
        chk("ac_setup", pre_rise, 32'd3);
        chk("ac_rs_held", rs_err, 32'd0);
        chk("ac_timeout", {31'd0, bus.timeout}, 32'd0);
        post_done(8'h45, 1'b0, 7'h45);

        // Data read returning 8'h61: RS high throughout, bf/ac forced to 0
        db_val = 8'h61;
        issue(1'b1, 1'b0);
        wait_done(1'b1, 200, 1'b0);
        chk("data_pulses", pulses, 32'd1);
        chk("data_rs_held", rs_err, 32'd0);
        chk("data_setup", pre_rise, 32'd3);
        post_done(8'h61, 1'b0, 7'h00);

        // Data read with req pulsed twice mid-transaction: no extra read
        db_val = 8'hC2;
        issue(1'b1, 1'b0);
        wait_done(1'b1, 200, 1'b1);
        chk("glitch_latency", n_cyc, 32'd53);
        chk("glitch_pulses", pulses, 32'd1);
        post_done(8'hC2, 1'b0, 7'h00);
        chk("glitch_idle", {31'd0, bus.busy}, 32'd0);

`ifdef LCD_READ_POLL_EN
        // Busy three times, then 8'h05: four E pulses, one done
        db_val = 8'h05; bf_reads = 3;
        issue(1'b0, 1'b0);
        wait_done(1'b0, 2000, 1'b0);
        chk("poll_pulses", pulses, 32'd4);
        chk("poll_e_width", high_total, 32'd100);
        chk("poll_timeout", {31'd0, bus.timeout}, 32'd0);
        post_done(8'h05, 1'b0, 7'h05);

        // BF stuck at 1: eight reads then give up with timeout
        db_val = 8'h11; bf_reads = 1000;
        issue(1'b0, 1'b0);
        wait_done(1'b0, 2000, 1'b0);
        chk("to_pulses", pulses, 32'd8);
        chk("to_timeout", {31'd0, bus.timeout}, 32'd1);
        rd = bus.rd_data;
        chk("to_bf_bit", {31'd0, rd[7]}, 32'd1);
        post_done(8'h91, 1'b1, 7'h11);
        bf_reads = 0;
`else
        // BF set, single-read build: exactly one read, BF reported
        db_val = 8'hC2; bf_reads = 0;
        issue(1'b0, 1'b0);
        wait_done(1'b0, 200, 1'b0);
        chk("bf_pulses", pulses, 32'd1);
        chk("bf_timeout", {31'd0, bus.timeout}, 32'd0);
        post_done(8'hC2, 1'b1, 7'h42);
`endif

        // req held high: idle one cycle after done, then next read starts
        db_val = 8'h3A;
        issue(1'b0, 1'b1);
        wait_done(1'b0, 200, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("hold_idle_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk("hold_restart_busy", {31'd0, bus.busy}, 32'd1);
        chk("hold_restart_rw", {31'd0, bus.lcd_rw}, 32'd1);
        wait_done(1'b0, 200, 1'b0);
        chk("hold_pulses", pulses, 32'd1);
        post_done(8'h3A, 1'b0, 7'h3A);

        // Reset during E high: E drops at once, results cleared, no done
        db_val = 8'h77;
        issue(1'b0, 1'b0);
        dcount = 0;
        while (bus.lcd_e !== 1'b1 && dcount < 20) begin
            @(posedge clk);
            #1;
            dcount++;
        end
        chk("mid_e_high_reached", {31'd0, bus.lcd_e}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_e", {31'd0, bus.lcd_e}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        chk("mid_rst_rw", {31'd0, bus.lcd_rw}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dcount++;
        end
        chk("mid_rst_no_done", dcount, 32'd0);

        chk("db_oe_never_set", {31'd0, oe_bad}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
